fetch_mem_sequencer: RTL and testbench
======================================

# fetch_mem_sequencer

Sequences instruction-memory reads on behalf of the RV32C fetch buffer. It takes the fetch buffer's word-aligned `imem_pc`, drives a single outstanding read on the instruction bus, and returns each word to the buffer as a one-cycle `inst_arrived` pulse. Redirects (branch/jump/trap) during an in-flight read drain and discard the stale response, and a watchdog flags hung reads. It sits between `fetch_buffer` and the instruction-side generic bus.

## Interface
- `TIMEOUT`, 255: bus wait cycles in REQ/DISCARD before `fetch_fault` sets; must be ≥1.
- `clk`  in  1  core clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `fetch_en`  in  1  permits new reads; low parks the block in IDLE after the current transaction.
- `imem_pc`  in  32  next fetch address from `fetch_buffer`; bits [1:0] ignored.
- `redirect`  in  1  flush/redirect; same signal as `fetch_buffer` `reset_en`.
- `fetch_stall`  in  1  pipeline cannot accept a word this cycle.
- `inst`  out  32  last captured read data; valid while `inst_arrived` is high.
- `inst_arrived`  out  1  one-cycle data-valid pulse to `fetch_buffer`.
- `fetch_fault`  out  1  sticky watchdog flag.
- `ren`  out  1  bus read request.
- `addr`  out  32  bus address, always `{pc[31:2],2'b00}`.
- `rdata`  in  32  bus read data, valid in the cycle `busy` is low.
- `busy`  in  1  bus not ready; a read completes in a cycle with `ren`=1 and `busy`=0.

## Operation
- States: IDLE, REQ, DISCARD, VALID.
- IDLE: `ren`=0. If `fetch_en` and no `redirect`, latch `addr` from `imem_pc` and go to REQ.
- REQ: `ren`=1, `addr` held stable.
  - If `busy`=0: capture `rdata` into `inst`.
    - With `redirect` in the same cycle, go to IDLE and drop the data.
    - Otherwise go to VALID.
  - If `busy`=1 with `redirect`: go to DISCARD.
- DISCARD: `ren`=1 and `addr` unchanged until `busy`=0. The bus transaction is never abandoned. Data is dropped, then go to IDLE. Further `redirect`s here are ignored.
- VALID: `inst_arrived` = !`fetch_stall` && !`redirect`.
  - `redirect`: go to IDLE.
  - `fetch_stall`: stay in VALID, holding `inst`.
  - Otherwise, with `fetch_en`: latch `addr` from `imem_pc` and go to REQ. `fetch_buffer` has updated `imem_pc` at this edge; the latch samples the post-update value in the REQ entry cycle.
  - Otherwise: go to IDLE.
- Watchdog: counts consecutive cycles with `ren`=1 and `busy`=1, saturating at TIMEOUT. On reaching TIMEOUT, set `fetch_fault`. The counter clears on any completion. `fetch_fault` clears only on `redirect` or `rst`.
- `redirect` has priority over `fetch_stall` and over `fetch_en`.

## Timing
- Reset values: state IDLE, `ren`=0, `addr`=0, `inst`=0, `inst_arrived`=0, `fetch_fault`=0, watchdog count 0.
- `ren` and `inst_arrived` decode from registered state only. There is no combinational path from `busy` or `rdata` to outputs.
- Zero-wait bus: IDLE→REQ→VALID→REQ. One word every 2 cycles; first `inst_arrived` 2 cycles after `fetch_en` rises.
- N wait cycles: `inst_arrived` occurs N+1 cycles after REQ entry.
- `rst` mid-transaction: state returns to IDLE immediately. Any later bus response is not tracked; the bus is reset on the same `rst`.
- `fetch_en` falling in REQ does not cancel the read. The word is still delivered via VALID, then the block idles.

## Structure
- Package `fetch_seq_pkg`: state enum `fetch_seq_state_t` and `FETCH_SEQ_TIMEOUT_DEFAULT`.
- Sub-module `fetch_watchdog`: saturating counter of width `$clog2(TIMEOUT+1)` plus the sticky fault flag, with inputs `count_en`, `clear`, `fault_clr`.
- The top level holds the FSM, the `addr` latch and the `inst` register.

## Test plan
- Zero-wait bus, `imem_pc` stepping 0x100, 0x104, 0x108 -> `addr` 0x100/0x104/0x108, `inst_arrived` every 2nd cycle with matching `rdata`.
- `busy` high 3 cycles on read of 0x200 -> `addr` stable 0x200 for 4 cycles; `inst_arrived` 1 cycle after `busy` falls.
- `redirect` to 0x402 while `busy`=1 on 0x300 -> DISCARD, no `inst_arrived` for 0x300, next `addr`=0x400.
- `fetch_stall` held 2 cycles in VALID with `inst`=0xDEADBEEF -> no pulse, `inst` held, single pulse when stall drops.
- TIMEOUT=4, `busy` stuck high -> `fetch_fault`=1 on 4th wait cycle, stays set after completion, clears on `redirect`.
- `rst` asserted in REQ -> `ren`=0, `addr`=0, state IDLE without waiting for a clock edge.

Source files
------------

// File: rtl/fetch_mem_sequencer_pkg.sv
// Shared types and defaults for the instruction-fetch memory sequencer.
package fetch_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_DISCARD,
    ST_VALID
  } fetch_seq_state_t;

  localparam int FETCH_SEQ_TIMEOUT_DEFAULT = 255;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_mem_sequencer_if.sv
// Instruction-side generic bus: single outstanding read, busy-stretched.
interface fetch_mem_sequencer_if;
  logic        ren;
  logic [31:0] addr;
  logic [31:0] rdata;
  logic        busy;

  modport master (output ren, output addr, input rdata, input busy);
  modport slave  (input ren, input addr, output rdata, output busy);
endinterface

// File: rtl/fetch_mem_sequencer_watchdog.sv
// Saturating bus-wait counter with a sticky fault flag for hung reads.
module fetch_watchdog
  import fetch_seq_pkg::*;
#(
  parameter int TIMEOUT = FETCH_SEQ_TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic count_en,
  input  logic clear,
  input  logic fault_clr,
  output logic fault
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (count_en && (count != CNT_MAX)) begin
      count <= count + 1'b1;
    end
  end

  // Fault rises on the wait cycle that brings the count to TIMEOUT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fault <= 1'b0;
    end else if (fault_clr) begin
      fault <= 1'b0;
    end else if (count_en && (count >= CNT_MAX - 1'b1)) begin
      fault <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_mem_sequencer.sv
// Drives one outstanding instruction read at a time and hands each word to the fetch buffer.
module fetch_mem_sequencer
  import fetch_seq_pkg::*;
#(
  parameter int TIMEOUT = FETCH_SEQ_TIMEOUT_DEFAULT
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         fetch_en,
  input  logic [31:0]                  imem_pc,
  input  logic                         redirect,
  input  logic                         fetch_stall,
  output logic [31:0]                  inst,
  output logic                         inst_arrived,
  output logic                         fetch_fault,
  fetch_mem_sequencer_if.master        bus
);

  fetch_seq_state_t state, state_nxt;
  logic             req_entry;
  logic [31:0]      addr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (fetch_en && !redirect) state_nxt = ST_REQ;
      end
      ST_REQ: begin
        if (!bus.busy)     state_nxt = redirect ? ST_IDLE : ST_VALID;
        else if (redirect) state_nxt = ST_DISCARD;
      end
      ST_DISCARD: begin
        if (!bus.busy) state_nxt = ST_IDLE;
      end
      ST_VALID: begin
        if (redirect)         state_nxt = ST_IDLE;
        else if (fetch_stall) state_nxt = ST_VALID;
        else if (fetch_en)    state_nxt = ST_REQ;
        else                  state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // The fetch buffer advances imem_pc on the same edge that enters REQ, so the
  // address is taken from imem_pc during the entry cycle and held from then on.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_entry <= 1'b0;
      addr_q    <= '0;
      inst      <= '0;
    end else begin
      req_entry <= (state_nxt == ST_REQ) && (state != ST_REQ);
      if (req_entry) addr_q <= word_align(imem_pc);
      if ((state == ST_REQ) && !bus.busy) inst <= bus.rdata;
    end
  end

  assign bus.ren      = (state == ST_REQ) || (state == ST_DISCARD);
  assign bus.addr     = req_entry ? word_align(imem_pc) : addr_q;
  assign inst_arrived = (state == ST_VALID) && !fetch_stall && !redirect;

  fetch_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk       (clk),
    .rst       (rst),
    .count_en  (bus.ren && bus.busy),
    .clear     (bus.ren && !bus.busy),
    .fault_clr (redirect),
    .fault     (fetch_fault)
  );

endmodule

// File: tb/tb_fetch_mem_sequencer.sv
// Directed bench for fetch_mem_sequencer with a small watchdog TIMEOUT.
module tb_fetch_mem_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        fetch_en = 1'b0;
  logic [31:0] imem_pc = '0;
  logic        redirect = 1'b0;
  logic        fetch_stall = 1'b0;
  logic [31:0] inst;
  logic        inst_arrived;
  logic        fetch_fault;
  int          n_tests = 0;
  int          n_fail = 0;

  fetch_mem_sequencer_if bus ();

  fetch_mem_sequencer #(
    .TIMEOUT (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .fetch_en     (fetch_en),
    .imem_pc      (imem_pc),
    .redirect     (redirect),
    .fetch_stall  (fetch_stall),
    .inst         (inst),
    .inst_arrived (inst_arrived),
    .fetch_fault  (fetch_fault),
    .bus          (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "bench timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.busy = 1'b0;
    bus.rdata = 32'h0;
    #1 rst = 1'b1;
    #1;
    n_tests++; if (bus.ren !== 1'b0) begin n_fail++; $display("FAIL rst_ren: got %b expected 0", bus.ren); end
    n_tests++; if (bus.addr !== 32'h0) begin n_fail++; $display("FAIL rst_addr: got %h expected 00000000", bus.addr); end
    n_tests++; if (inst !== 32'h0) begin n_fail++; $display("FAIL rst_inst: got %h expected 00000000", inst); end
    n_tests++; if (inst_arrived !== 1'b0) begin n_fail++; $display("FAIL rst_arrived: got %b expected 0", inst_arrived); end
    n_tests++; if (fetch_fault !== 1'b0) begin n_fail++; $display("FAIL rst_fault: got %b expected 0", fetch_fault); end
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_zero_wait();
    logic [31:0] pc;
    logic [31:0] data;
    imem_pc = 32'h100;
    fetch_en = 1'b1;
    bus.busy = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      pc = 32'h100 + 32'(4 * i);
      data = 32'hA000_0000 | pc;
      imem_pc = pc;
      bus.rdata = data;
      #1;
      n_tests++; if (bus.ren !== 1'b1) begin n_fail++; $display("FAIL zw_ren[%0d]: got %b expected 1", i, bus.ren); end
      n_tests++; if (bus.addr !== pc) begin n_fail++; $display("FAIL zw_addr[%0d]: got %h expected %h", i, bus.addr, pc); end
      n_tests++; if (inst_arrived !== 1'b0) begin n_fail++; $display("FAIL zw_early[%0d]: got %b expected 0", i, inst_arrived); end
      tick();
      fetch_en = (i < 2);
      #1;
      n_tests++; if (inst_arrived !== 1'b1) begin n_fail++; $display("FAIL zw_pulse[%0d]: got %b expected 1", i, inst_arrived); end
      n_tests++; if (inst !== data) begin n_fail++; $display("FAIL zw_inst[%0d]: got %h expected %h", i, inst, data); end
      tick();
    end
    #1;
    n_tests++; if (bus.ren !== 1'b0) begin n_fail++; $display("FAIL zw_idle_ren: got %b expected 0", bus.ren); end
  endtask

  // Three busy cycles; fetch_en drops mid-read but the word is still delivered.
  task automatic test_wait_states();
    imem_pc = 32'h200;
    fetch_en = 1'b1;
    bus.busy = 1'b1;
    bus.rdata = 32'hFFFF_FFFF;
    tick();
    fetch_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.busy = (i < 3);
      bus.rdata = (i < 3) ? 32'hFFFF_FFFF : 32'hB000_0200;
      #1;
      n_tests++; if (bus.addr !== 32'h200 || bus.ren !== 1'b1) begin n_fail++; $display("FAIL ws_addr[%0d]: got %h/%b expected 00000200/1", i, bus.addr, bus.ren); end
      n_tests++; if (inst_arrived !== 1'b0) begin n_fail++; $display("FAIL ws_early[%0d]: got %b expected 0", i, inst_arrived); end
      tick();
    end
    #1;
    n_tests++; if (inst_arrived !== 1'b1) begin n_fail++; $display("FAIL ws_pulse: got %b expected 1", inst_arrived); end
    n_tests++; if (inst !== 32'hB000_0200) begin n_fail++; $display("FAIL ws_inst: got %h expected b0000200", inst); end
    n_tests++; if (bus.ren !== 1'b0) begin n_fail++; $display("FAIL ws_valid_ren: got %b expected 0", bus.ren); end
    tick();
    #1;
    n_tests++; if (bus.ren !== 1'b0 || fetch_fault !== 1'b0) begin n_fail++; $display("FAIL ws_idle: got ren %b fault %b expected 0/0", bus.ren, fetch_fault); end
  endtask

  task automatic test_discard();
    imem_pc = 32'h300;
    fetch_en = 1'b1;
    bus.busy = 1'b1;
    tick();
    #1;
    n_tests++; if (bus.addr !== 32'h300) begin n_fail++; $display("FAIL dc_addr0: got %h expected 00000300", bus.addr); end
    tick();
    redirect = 1'b1;
    imem_pc = 32'h402;
    #1;
    n_tests++; if (bus.addr !== 32'h300) begin n_fail++; $display("FAIL dc_addr1: got %h expected 00000300", bus.addr); end
    tick();
    #1;
    n_tests++; if (bus.ren !== 1'b1 || bus.addr !== 32'h300) begin n_fail++; $display("FAIL dc_hold0: got %b/%h expected 1/00000300", bus.ren, bus.addr); end
    n_tests++; if (inst_arrived !== 1'b0) begin n_fail++; $display("FAIL dc_pulse0: got %b expected 0", inst_arrived); end
    tick();
    redirect = 1'b0;
    bus.busy = 1'b0;
    bus.rdata = 32'hC000_0300;
    #1;
    n_tests++; if (bus.ren !== 1'b1 || bus.addr !== 32'h300) begin n_fail++; $display("FAIL dc_hold1: got %b/%h expected 1/00000300", bus.ren, bus.addr); end
    tick();
    bus.rdata = 32'hD000_0400;
    #1;
    n_tests++; if (bus.ren !== 1'b0 || inst_arrived !== 1'b0) begin n_fail++; $display("FAIL dc_idle: got ren %b pulse %b expected 0/0", bus.ren, inst_arrived); end
    tick();
    #1;
    n_tests++; if (bus.addr !== 32'h400 || bus.ren !== 1'b1) begin n_fail++; $display("FAIL dc_newaddr: got %h/%b expected 00000400/1", bus.addr, bus.ren); end
    tick();
    fetch_en = 1'b0;
    #1;
    n_tests++; if (inst_arrived !== 1'b1 || inst !== 32'hD000_0400) begin n_fail++; $display("FAIL dc_newword: got %b/%h expected 1/d0000400", inst_arrived, inst); end
    tick();
  endtask

  task automatic test_stall();
    imem_pc = 32'h500;
    fetch_en = 1'b1;
    bus.busy = 1'b0;
    bus.rdata = 32'hDEAD_BEEF;
    tick();
    fetch_en = 1'b0;
    tick();
    bus.rdata = 32'h1234_5678;
    for (int i = 0; i < 3; i++) begin
      fetch_stall = (i < 2);
      #1;
      n_tests++; if (inst_arrived !== (i == 2)) begin n_fail++; $display("FAIL st_pulse[%0d]: got %b expected %b", i, inst_arrived, (i == 2)); end
      n_tests++; if (inst !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL st_inst[%0d]: got %h expected deadbeef", i, inst); end
      tick();
    end
    fetch_stall = 1'b0;
    #1;
    n_tests++; if (inst_arrived !== 1'b0 || bus.ren !== 1'b0) begin n_fail++; $display("FAIL st_after: got pulse %b ren %b expected 0/0", inst_arrived, bus.ren); end
  endtask

  // With TIMEOUT=4 the flag is visible from the cycle after the 4th wait cycle.
  task automatic test_timeout();
    imem_pc = 32'h600;
    fetch_en = 1'b1;
    bus.busy = 1'b1;
    tick();
    fetch_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_tests++; if (fetch_fault !== 1'b0) begin n_fail++; $display("FAIL to_early[%0d]: got %b expected 0", i, fetch_fault); end
      tick();
    end
    bus.busy = 1'b0;
    bus.rdata = 32'hE000_0600;
    #1;
    n_tests++; if (fetch_fault !== 1'b1) begin n_fail++; $display("FAIL to_set: got %b expected 1", fetch_fault); end
    tick();
    #1;
    n_tests++; if (fetch_fault !== 1'b1 || inst_arrived !== 1'b1) begin n_fail++; $display("FAIL to_sticky: got fault %b pulse %b expected 1/1", fetch_fault, inst_arrived); end
    redirect = 1'b1;
    #1;
    n_tests++; if (inst_arrived !== 1'b0) begin n_fail++; $display("FAIL to_redir_pulse: got %b expected 0", inst_arrived); end
    tick();
    redirect = 1'b0;
    #1;
    n_tests++; if (fetch_fault !== 1'b0 || bus.ren !== 1'b0) begin n_fail++; $display("FAIL to_clear: got fault %b ren %b expected 0/0", fetch_fault, bus.ren); end
  endtask

  task automatic test_async_rst();
    imem_pc = 32'h700;
    fetch_en = 1'b1;
    bus.busy = 1'b1;
    tick();
    fetch_en = 1'b0;
    #1;
    n_tests++; if (bus.ren !== 1'b1 || bus.addr !== 32'h700) begin n_fail++; $display("FAIL ar_req: got %b/%h expected 1/00000700", bus.ren, bus.addr); end
    #1 rst = 1'b1;
    #1;
    n_tests++; if (bus.ren !== 1'b0 || bus.addr !== 32'h0) begin n_fail++; $display("FAIL ar_bus: got %b/%h expected 0/00000000", bus.ren, bus.addr); end
    n_tests++; if (inst !== 32'h0 || inst_arrived !== 1'b0) begin n_fail++; $display("FAIL ar_inst: got %h/%b expected 00000000/0", inst, inst_arrived); end
    tick();
    rst = 1'b0;
    bus.busy = 1'b0;
    tick();
    #1;
    n_tests++; if (bus.ren !== 1'b0 || fetch_fault !== 1'b0) begin n_fail++; $display("FAIL ar_idle: got ren %b fault %b expected 0/0", bus.ren, fetch_fault); end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_discard();
    test_stall();
    test_timeout();
    test_async_rst();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
